regfile_wb_scheduler: RTL

//  Writeback scheduler for a single-write-port Y86 register file. Decodes dstE/dstM

---
 rtl/y86_pkg.sv | 32 +++
 rtl/wb_dest_decode.sv | 42 ++++
 rtl/regfile_wb_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
//------------------------------------------------------------------------------
// Module  : y86_pkg
// Brief   : Shared Y86 icode/register constants and the writeback entry type.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_CMOVXX = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam int PKG_AW = 4;
  localparam int PKG_DW = 64;

  localparam logic [PKG_AW-1:0] REG_RSP  = 4'd4;
  localparam logic [PKG_AW-1:0] REG_NONE = 4'd15;

  typedef struct packed {
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_dest_decode.sv
//------------------------------------------------------------------------------
// Module  : wb_dest_decode
// Brief   : Combinational dstE/dstM decode; REG_NONE marks "no write".
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_dest_decode
  import y86_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [3:0]    icode_i,
  input  logic [AW-1:0] ra_i,
  input  logic [AW-1:0] rb_i,
  input  logic          cnd_i,
  output logic [AW-1:0] dst_e_o,
  output logic [AW-1:0] dst_m_o
);

  always_comb begin
    dst_e_o = AW'(REG_NONE);
    dst_m_o = AW'(REG_NONE);
    case (icode_i)
      I_CMOVXX: if (cnd_i) dst_e_o = rb_i;
      I_IRMOVQ,
      I_OPQ:    dst_e_o = rb_i;
      I_MRMOVQ: dst_m_o = ra_i;
      I_CALL,
      I_RET,
      I_PUSHQ:  dst_e_o = AW'(REG_RSP);
      I_POPQ: begin
        dst_e_o = AW'(REG_RSP);
        dst_m_o = ra_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
//------------------------------------------------------------------------------
// Module  : regfile_wb_scheduler
// Brief   : Queues decoded dstE/dstM writes, drains one per cycle to the RF.
//           Optional combinational forwarding lookup enabled by WB_FWD_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [3:0]               icode,
  input  logic [AW-1:0]            rA,
  input  logic [AW-1:0]            rB,
  input  logic                     cnd,
  input  logic [DW-1:0]            valE,
  input  logic [DW-1:0]            valM,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addr,
  output logic [DW-1:0]            rf_data,
  output logic [$clog2(DEPTH):0]   pending_cnt,
  output logic                     idle,
  input  logic [AW-1:0]            fwd_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] dst_e, dst_m;
  logic          accept, push_e, push_m, pop;
  logic [1:0]    n_push;
  wb_entry_t     entry_e, entry_m, entry_first;

  wb_entry_t     fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q;
  logic [AW-1:0] rf_addr_q;
  logic [DW-1:0] rf_data_q;

  wb_dest_decode #(.AW(AW)) u_decode (
    .icode_i (icode),
    .ra_i    (rA),
    .rb_i    (rB),
    .cnd_i   (cnd),
    .dst_e_o (dst_e),
    .dst_m_o (dst_m)
  );

  // Two free slots are required so a popq can always land both halves at once.
  assign wb_ready = (count_q <= CW'(DEPTH - 2));
  assign accept   = wb_valid && wb_ready;
  assign push_e   = accept && (dst_e != AW'(REG_NONE));
  assign push_m   = accept && (dst_m != AW'(REG_NONE));
  assign pop      = (count_q != '0);

  always_comb begin
    entry_e      = '{addr: dst_e, data: valE};
    entry_m      = '{addr: dst_m, data: valM};
    entry_first  = push_e ? entry_e : entry_m;
    n_push       = {1'b0, push_e} + {1'b0, push_m};
    count_d      = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d     = wr_ptr_q + PW'(n_push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rf_we_q  <= pop;
      if (pop) begin
        rf_addr_q <= fifo_q[rd_ptr_q].addr;
        rf_data_q <= fifo_q[rd_ptr_q].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_e || push_m) fifo_q[wr_ptr_q] <= entry_first;
      if (push_e && push_m) fifo_q[wr_ptr_q + PW'(1)] <= entry_m;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign pending_cnt = count_q;
  assign idle        = (count_q == '0) && !rf_we_q;

`ifdef WB_FWD_EN
  // Scan oldest to newest so the last match (newest write) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rf_we_q && (rf_addr_q == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (fifo_q[rd_ptr_q + PW'(i)].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[rd_ptr_q + PW'(i)].data;
      end
    end
    if (fwd_addr == AW'(REG_NONE)) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

`default_nettype wire
